// File: rtl/gen2_pkg.sv
// Shared Gen2 definitions: command encodings, opcodes, frame lengths and CRC constants.
// Used by the reader command generator and the tag-side blocks.
package gen2_pkg;

  typedef enum logic [2:0] {
    CMD_QUERYREP = 3'd0,
    CMD_ACK      = 3'd1,
    CMD_QUERY    = 3'd2,
    CMD_QUERYADJ = 3'd3,
    CMD_NACK     = 3'd4,
    CMD_REQRN    = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CRC_NONE = 2'd0,
    CRC_5    = 2'd1,
    CRC_16   = 2'd2
  } crc_kind_e;

  localparam logic [1:0] OP_QUERYREP = 2'b00;
  localparam logic [1:0] OP_ACK      = 2'b01;
  localparam logic [3:0] OP_QUERY    = 4'b1000;
  localparam logic [3:0] OP_QUERYADJ = 4'b1001;
  localparam logic [7:0] OP_NACK     = 8'b11000000;
  localparam logic [7:0] OP_REQRN    = 8'b11000001;

  // Total frame lengths on air, CRC included.
  localparam logic [5:0] LEN_QUERYREP = 6'd4;
  localparam logic [5:0] LEN_ACK      = 6'd18;
  localparam logic [5:0] LEN_QUERY    = 6'd22;
  localparam logic [5:0] LEN_QUERYADJ = 6'd9;
  localparam logic [5:0] LEN_NACK     = 6'd8;
  localparam logic [5:0] LEN_REQRN    = 6'd40;
  localparam logic [5:0] PLEN_QUERY   = 6'd17;
  localparam logic [5:0] PLEN_REQRN   = 6'd24;

  localparam logic [4:0]  CRC5_PRESET_DEF  = 5'b01001;
  localparam logic [4:0]  CRC5_POLY        = 5'b01001;
  localparam logic [15:0] CRC16_PRESET_DEF = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY       = 16'h1021;

  function automatic logic cmd_legal(input logic [2:0] c);
    return (c <= 3'd5);
  endfunction

endpackage

// File: rtl/crc_serial.sv
// Serial CRC5 and CRC16 LFSRs. Preset loads both, enable clocks one data bit in,
// shift freezes feedback and moves the register out MSB first.
module crc_serial
  import gen2_pkg::*;
#(
  parameter logic [4:0]  CRC5_PRESET  = CRC5_PRESET_DEF,
  parameter logic [15:0] CRC16_PRESET = CRC16_PRESET_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic preset,
  input  logic enable,
  input  logic shift,
  input  logic din,
  output logic crc5_msb,
  output logic crc16_msb
);

  logic [4:0]  crc5_q,  crc5_d;
  logic [15:0] crc16_q, crc16_d;

  always_comb begin
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    if (preset) begin
      crc5_d  = CRC5_PRESET;
      crc16_d = CRC16_PRESET;
    end else if (enable) begin
      crc5_d  = {crc5_q[3:0], 1'b0}  ^ ((crc5_q[4]  ^ din) ? CRC5_POLY  : 5'd0);
      crc16_d = {crc16_q[14:0], 1'b0} ^ ((crc16_q[15] ^ din) ? CRC16_POLY : 16'd0);
    end else if (shift) begin
      crc5_d  = {crc5_q[3:0], 1'b0};
      crc16_d = {crc16_q[14:0], 1'b0};
    end else begin
      crc5_d  = crc5_q;
      crc16_d = crc16_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc5_q  <= 5'd0;
      crc16_q <= 16'd0;
    end else begin
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
    end
  end

  assign crc5_msb  = crc5_q[4];
  assign crc16_msb = crc16_q[15];

endmodule

// File: rtl/reader_cmdgen.sv
// Reader-side Gen2 command serializer: latches a command, shifts it out MSB first
// one bit per bitclk and appends CRC5 (Query) or inverted CRC16 (ReqRN).
module reader_cmdgen
  import gen2_pkg::*;
#(
  parameter logic [4:0]  CRC5_PRESET  = CRC5_PRESET_DEF,
  parameter logic [15:0] CRC16_PRESET = CRC16_PRESET_DEF
) (
  input  logic        bitclk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  cmd_sel,
  input  logic [1:0]  session,
  input  logic [15:0] rn16,
  input  logic        dr,
  input  logic [1:0]  m,
  input  logic        trext,
  input  logic [1:0]  sel,
  input  logic        target,
  input  logic [3:0]  q,
  input  logic [2:0]  updn,
  output logic        bitout,
  output logic        bitout_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e    state_q, state_d;
  logic [23:0] shreg_q, shreg_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  plen_q, plen_d;
  logic [5:0]  tlen_q, tlen_d;
  crc_kind_e kind_q, kind_d;
  logic bitout_q, bitout_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic accept_s, reject_s, last_payload_s, last_bit_s;
  logic crc5_msb_s, crc16_msb_s;

  // busy_q also covers the done cycle, so a start there is ignored.
  assign accept_s       = (state_q == ST_IDLE) && !busy_q && start &&  cmd_legal(cmd_sel);
  assign reject_s       = (state_q == ST_IDLE) && !busy_q && start && !cmd_legal(cmd_sel);
  assign last_payload_s = (state_q == ST_PAYLOAD) && (cnt_q == plen_q - 6'd1);
  assign last_bit_s     = (state_q != ST_IDLE) && (cnt_q == tlen_q - 6'd1);

  crc_serial #(
    .CRC5_PRESET  (CRC5_PRESET),
    .CRC16_PRESET (CRC16_PRESET)
  ) u_crc (
    .clk       (bitclk),
    .reset     (reset),
    .preset    (accept_s),
    .enable    (state_q == ST_PAYLOAD),
    .shift     (state_q == ST_CRC),
    .din       (shreg_q[23]),
    .crc5_msb  (crc5_msb_s),
    .crc16_msb (crc16_msb_s)
  );

  always_ff @(posedge bitclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_PAYLOAD;
        else          state_d = ST_IDLE;
      end
      ST_PAYLOAD: begin
        if (last_payload_s) state_d = (kind_q == CRC_NONE) ? ST_IDLE : ST_CRC;
        else                state_d = ST_PAYLOAD;
      end
      ST_CRC: begin
        if (last_bit_s) state_d = ST_IDLE;
        else            state_d = ST_CRC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    plen_d  = plen_q;
    tlen_d  = tlen_q;
    kind_d  = kind_q;
    if (accept_s) begin
      cnt_d = 6'd0;
      case (cmd_sel)
        CMD_QUERYREP: begin
          shreg_d = {OP_QUERYREP, session, 20'd0};
          plen_d = LEN_QUERYREP; tlen_d = LEN_QUERYREP; kind_d = CRC_NONE;
        end
        CMD_ACK: begin
          shreg_d = {OP_ACK, rn16, 6'd0};
          plen_d = LEN_ACK; tlen_d = LEN_ACK; kind_d = CRC_NONE;
        end
        CMD_QUERY: begin
          shreg_d = {OP_QUERY, dr, m, trext, sel, session, target, q, 7'd0};
          plen_d = PLEN_QUERY; tlen_d = LEN_QUERY; kind_d = CRC_5;
        end
        CMD_QUERYADJ: begin
          shreg_d = {OP_QUERYADJ, session, updn, 15'd0};
          plen_d = LEN_QUERYADJ; tlen_d = LEN_QUERYADJ; kind_d = CRC_NONE;
        end
        CMD_NACK: begin
          shreg_d = {OP_NACK, 16'd0};
          plen_d = LEN_NACK; tlen_d = LEN_NACK; kind_d = CRC_NONE;
        end
        CMD_REQRN: begin
          shreg_d = {OP_REQRN, rn16};
          plen_d = PLEN_REQRN; tlen_d = LEN_REQRN; kind_d = CRC_16;
        end
        default: begin
          shreg_d = 24'd0;
          plen_d = 6'd0; tlen_d = 6'd0; kind_d = CRC_NONE;
        end
      endcase
    end else if (state_q == ST_PAYLOAD) begin
      shreg_d = {shreg_q[22:0], 1'b0};
      cnt_d   = last_bit_s ? 6'd0 : cnt_q + 6'd1;
    end else if (state_q == ST_CRC) begin
      cnt_d = last_bit_s ? 6'd0 : cnt_q + 6'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    bitout_d = 1'b0;
    case (state_q)
      ST_PAYLOAD: bitout_d = shreg_q[23];
      ST_CRC:     bitout_d = (kind_q == CRC_16) ? ~crc16_msb_s : crc5_msb_s;
      default:    bitout_d = 1'b0;
    endcase
    busy_d = (state_q != ST_IDLE);
    done_d = last_bit_s;
    err_d  = reject_s;
  end

  always_ff @(posedge bitclk or posedge reset) begin
    if (reset) begin
      shreg_q  <= 24'd0;
      cnt_q    <= 6'd0;
      plen_q   <= 6'd0;
      tlen_q   <= 6'd0;
      kind_q   <= CRC_NONE;
      bitout_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      plen_q   <= plen_d;
      tlen_q   <= tlen_d;
      kind_q   <= kind_d;
      bitout_q <= bitout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bitout       = bitout_q;
  assign bitout_valid = busy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_reader_cmdgen.sv
// Directed bench for reader_cmdgen: frame contents, CRC tails, timing, err, ignored
// start while busy and asynchronous reset mid-frame.
module tb_reader_cmdgen;
  import gen2_pkg::*;

  logic        bitclk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  cmd_sel = 3'd0;
  logic [1:0]  session = 2'd0;
  logic [15:0] rn16 = 16'd0;
  logic        dr = 1'b0;
  logic [1:0]  m = 2'd0;
  logic        trext = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        target = 1'b0;
  logic [3:0]  q = 4'd0;
  logic [2:0]  updn = 3'd0;
  logic        bitout, bitout_valid, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  reader_cmdgen dut (
    .bitclk(bitclk), .reset(reset), .start(start), .cmd_sel(cmd_sel),
    .session(session), .rn16(rn16), .dr(dr), .m(m), .trext(trext), .sel(sel),
    .target(target), .q(q), .updn(updn), .bitout(bitout),
    .bitout_valid(bitout_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 bitclk = ~bitclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference CRCs, MSB-first over the top n bits of b.
  function automatic logic [4:0] crc5_calc(input logic [63:0] b, input int n);
    logic [4:0] c = 5'b01001;
    for (int i = 0; i < n; i++) begin
      logic fb = c[4] ^ b[63-i];
      c = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'b01001;
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_calc(input logic [63:0] b, input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      logic fb = c[15] ^ b[63-i];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic issue(input logic [2:0] cs);
    @(negedge bitclk);
    cmd_sel = cs;
    start = 1'b1;
    @(negedge bitclk);
    start = 1'b0;
  endtask

  // Collect bits from the first valid cycle until bitout_valid drops.
  task automatic capture(output logic [63:0] bits, output int n, output int done_at, output int done_cnt);
    bits = 64'd0; n = 0; done_at = -1; done_cnt = 0;
    @(negedge bitclk);
    while (bitout_valid === 1'b1 && n < 64) begin
      bits[63-n] = bitout;
      if (done === 1'b1) begin done_at = n; done_cnt++; end
      n++;
      @(negedge bitclk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge bitclk);
    n_checks++;
    if ({bitout, bitout_valid, busy, done, err} !== 5'b0) begin
      n_errors++; $display("FAIL reset_held: outputs=%b expected 00000", {bitout, bitout_valid, busy, done, err});
    end
    reset = 1'b0;
    repeat (2) @(negedge bitclk);
    n_checks++;
    if ({bitout, bitout_valid, busy, done, err} !== 5'b0) begin
      n_errors++; $display("FAIL reset_released: outputs=%b expected 00000", {bitout, bitout_valid, busy, done, err});
    end
  endtask

  task automatic test_queryrep();
    logic [63:0] b; int n, da, dc;
    session = 2'b10;
    issue(CMD_QUERYREP);
    capture(b, n, da, dc);
    n_checks++;
    if (n != 4) begin n_errors++; $display("FAIL queryrep_len: got %0d expected 4", n); end
    n_checks++;
    if (b[63:60] !== 4'b0010) begin n_errors++; $display("FAIL queryrep_bits: got %b expected 0010", b[63:60]); end
    n_checks++;
    if (da != 3 || dc != 1) begin n_errors++; $display("FAIL queryrep_done: at %0d count %0d expected at 3 count 1", da, dc); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL queryrep_busy_drop: got %b expected 0", busy); end
  endtask

  task automatic test_nack();
    logic [63:0] b; int n, da, dc;
    issue(CMD_NACK);
    capture(b, n, da, dc);
    n_checks++;
    if (n != 8 || b[63:56] !== 8'b11000000) begin
      n_errors++; $display("FAIL nack_frame: got len %0d bits %b expected len 8 bits 11000000", n, b[63:56]);
    end
    n_checks++;
    if (da != 7 || dc != 1) begin n_errors++; $display("FAIL nack_done: at %0d count %0d expected at 7 count 1", da, dc); end
  endtask

  task automatic test_query();
    logic [63:0] b; int n, da, dc;
    logic [16:0] exp_pl;
    dr = 1'b1; m = 2'b01; trext = 1'b0; sel = 2'b00; session = 2'b00; target = 1'b0; q = 4'd4;
    exp_pl = 17'b1000_1_01_0_00_00_0_0100;
    issue(CMD_QUERY);
    dr = 1'b0; q = 4'd15;
    capture(b, n, da, dc);
    n_checks++;
    if (n != 22) begin n_errors++; $display("FAIL query_len: got %0d expected 22", n); end
    n_checks++;
    if (b[63:47] !== exp_pl) begin n_errors++; $display("FAIL query_payload: got %b expected %b", b[63:47], exp_pl); end
    n_checks++;
    if (b[46:42] !== crc5_calc(b, 17)) begin
      n_errors++; $display("FAIL query_crc5: got %b expected %b", b[46:42], crc5_calc(b, 17));
    end
    n_checks++;
    if (crc5_calc(b, 22) !== 5'd0) begin n_errors++; $display("FAIL query_crc5_residue: got %b expected 00000", crc5_calc(b, 22)); end
    n_checks++;
    if (da != 21 || dc != 1) begin n_errors++; $display("FAIL query_done: at %0d count %0d expected at 21 count 1", da, dc); end
  endtask

  task automatic test_reqrn();
    logic [63:0] b; int n, da, dc;
    rn16 = 16'hA5C3;
    issue(CMD_REQRN);
    capture(b, n, da, dc);
    n_checks++;
    if (n != 40) begin n_errors++; $display("FAIL reqrn_len: got %0d expected 40", n); end
    n_checks++;
    if (b[63:40] !== 24'b11000001_1010010111000011) begin
      n_errors++; $display("FAIL reqrn_payload: got %h expected c1a5c3", b[63:40]);
    end
    n_checks++;
    if (b[39:24] !== ~crc16_calc(b, 24)) begin
      n_errors++; $display("FAIL reqrn_crc16: got %h expected %h", b[39:24], ~crc16_calc(b, 24));
    end
    n_checks++;
    if (crc16_calc(b, 40) !== 16'h1D0F) begin
      n_errors++; $display("FAIL reqrn_residue: got %h expected 1d0f", crc16_calc(b, 40));
    end
    n_checks++;
    if (da != 39 || dc != 1) begin n_errors++; $display("FAIL reqrn_done: at %0d count %0d expected at 39 count 1", da, dc); end
  endtask

  task automatic test_illegal();
    @(negedge bitclk);
    cmd_sel = 3'd7;
    start = 1'b1;
    @(negedge bitclk);
    start = 1'b0;
    n_checks++;
    if ({err, busy, bitout_valid} !== 3'b100) begin
      n_errors++; $display("FAIL illegal_err: err/busy/valid=%b expected 100", {err, busy, bitout_valid});
    end
    @(negedge bitclk);
    n_checks++;
    if ({err, busy, bitout_valid} !== 3'b000) begin
      n_errors++; $display("FAIL illegal_err_pulse: err/busy/valid=%b expected 000", {err, busy, bitout_valid});
    end
  endtask

  task automatic test_start_while_busy();
    logic [63:0] b = 64'd0; int n = 0; int da = -1;
    rn16 = 16'h3C5A;
    issue(CMD_ACK);
    start = 1'b1; cmd_sel = CMD_NACK; rn16 = 16'hFFFF;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge bitclk);
      if (bitout_valid === 1'b1) begin
        b[63-n] = bitout;
        if (done === 1'b1) da = n;
        n++;
      end else if (n > 0) begin
        break;
      end
    end
    start = 1'b0;
    n_checks++;
    if (n != 18 || b[63:46] !== {2'b01, 16'h3C5A}) begin
      n_errors++; $display("FAIL ack_busy_frame: got len %0d bits %b expected len 18 bits %b", n, b[63:46], {2'b01, 16'h3C5A});
    end
    n_checks++;
    if (da != 17) begin n_errors++; $display("FAIL ack_busy_done: at %0d expected 17", da); end
    repeat (2) @(negedge bitclk);
    n_checks++;
    if ({bitout_valid, err} !== 2'b00) begin
      n_errors++; $display("FAIL ack_busy_no_restart: valid/err=%b expected 00", {bitout_valid, err});
    end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] b; int n, da, dc;
    int seen = 0;
    dr = 1'b1; m = 2'b01; q = 4'd4;
    issue(CMD_QUERY);
    repeat (10) begin
      @(negedge bitclk);
      if (bitout_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 10) begin n_errors++; $display("FAIL midframe_prefix: got %0d valid bits expected 10", seen); end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({bitout, bitout_valid, busy, done, err} !== 5'b0) begin
      n_errors++; $display("FAIL midframe_async_reset: outputs=%b expected 00000", {bitout, bitout_valid, busy, done, err});
    end
    @(negedge bitclk);
    n_checks++;
    if ({bitout_valid, done} !== 2'b00) begin
      n_errors++; $display("FAIL midframe_no_done: valid/done=%b expected 00", {bitout_valid, done});
    end
    reset = 1'b0;
    session = 2'b01; updn = 3'b110;
    issue(CMD_QUERYADJ);
    capture(b, n, da, dc);
    n_checks++;
    if (n != 9 || b[63:55] !== 9'b1001_01_110) begin
      n_errors++; $display("FAIL queryadj_frame: got len %0d bits %b expected len 9 bits 100101110", n, b[63:55]);
    end
    n_checks++;
    if (da != 8 || dc != 1) begin n_errors++; $display("FAIL queryadj_done: at %0d count %0d expected at 8 count 1", da, dc); end
  endtask

  initial begin
    test_reset();
    test_queryrep();
    test_nack();
    test_query();
    test_reqrn();
    test_illegal();
    test_start_while_busy();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
